sdram_bus_arbiter: RTL

- Shares the single SDRAM slave bus between two bus masters: master 0 is the image write path, master 1 is the read/fetch path.
- Registered grant with round-robin on contention and a burst cap per master.
- ACK is routed back only to the granted master.
- A per-transaction watchdog aborts hung transfers and flags a sticky error.

---
 rtl/sdram_bus_arbiter_pkg.sv | 24 ++
 rtl/sdram_bus_watchdog.sv | 49 ++++
 rtl/sdram_bus_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sdram_bus_arbiter_pkg.sv
// rtl/sdram_bus_arbiter_pkg.sv - shared constants for the SDRAM bus arbiter
// Purpose: FSM state encoding, master index constants and default bus widths
//          used by sdram_bus_arbiter and its testbench.
package sdram_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Grant state that serves master m.
  function automatic state_t gnt_state(input logic m);
    return (m == M1) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/sdram_bus_watchdog.sv
// rtl/sdram_bus_watchdog.sv - loadable cycle counter with terminal-count flag
// Purpose: counts enabled cycles and flags the cycle in which the TIMEOUT-th
//          enabled cycle is reached.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (highest priority)
//   load       : synchronous load of load_val
//   load_val   : preset value
//   en         : count enable
//   tc         : high while enabled and the count sits at TIMEOUT-1
module sdram_bus_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        tc
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Count parks at the terminal value so tc stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/sdram_bus_arbiter.sv
// rtl/sdram_bus_arbiter.sv - two-master arbiter for the shared SDRAM slave bus
// Purpose: registered round-robin grant with a per-master burst cap, ack
//          routed to the granted master only, per-transfer watchdog with a
//          sticky timeout flag.
// Ports:
//   iCLK, iRST          : clock, async active-low reset
//   iM0_* / iM1_*       : master requests (addr, read, write, byte enables, data)
//   oM0_ACK / oM1_ACK   : ack to the granted master
//   oM_RData            : slave read data broadcast to both masters
//   oAddr..oData, iACK, iRData : slave side of the bus
//   oGrant              : one-hot current grant, 00 = none
//   oTimeout            : sticky watchdog error
module sdram_bus_arbiter
  import sdram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] iM0_Addr,
  input  logic              iM0_Read,
  input  logic              iM0_Write,
  input  logic [1:0]        iM0_BE,
  input  logic [DATA_W-1:0] iM0_Data,
  output logic              oM0_ACK,
  input  logic [ADDR_W-1:0] iM1_Addr,
  input  logic              iM1_Read,
  input  logic              iM1_Write,
  input  logic [1:0]        iM1_BE,
  input  logic [DATA_W-1:0] iM1_Data,
  output logic              oM1_ACK,
  output logic [DATA_W-1:0] oM_RData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oRead,
  output logic              oWrite,
  output logic [1:0]        oBE,
  output logic [DATA_W-1:0] oData,
  input  logic              iACK,
  input  logic [DATA_W-1:0] iRData,
  output logic [1:0]        oGrant,
  output logic              oTimeout
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic       timeout_q, timeout_d;
  logic [1:0] grant_q, grant_d;

  logic req0, req1, in_gnt, gnt_m, cur_req, wd_tc, tie_pick;

  assign req0    = iM0_Read | iM0_Write;
  assign req1    = iM1_Read | iM1_Write;
  assign in_gnt  = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign gnt_m   = (state_q == ST_GNT1);
  assign cur_req = gnt_m ? req1 : req0;

  // Cleared whenever no grant is active, so every grant starts from zero.
  sdram_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (iCLK),
    .rst_n    (iRST),
    .clr      (~in_gnt),
    .load     (1'b0),
    .load_val (16'd0),
    .en       (in_gnt),
    .tc       (wd_tc)
  );

  always_comb begin
    // Round-robin favours the master not served last; a master that hit the
    // burst cap is always the last-served one, so the forced switch goes to
    // the other master.
    tie_pick = ~last_q;
    if (burst_q >= BURST_CAP) begin
      tie_pick = (last_q == M1) ? M0 : M1;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = gnt_state(tie_pick);
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        // Ack has priority over both withdraw and watchdog expiry.
        if (iACK) begin
          state_d = ST_TURN;
          last_d  = gnt_m;
          if (gnt_m == last_q) begin
            burst_d = (burst_q >= BURST_CAP) ? BURST_CAP : burst_q + 4'd1;
          end else begin
            burst_d = 4'd1;
          end
        end else if (!cur_req) begin
          state_d = ST_TURN;
        end else if (wd_tc) begin
          state_d   = ST_TURN;
          timeout_d = 1'b1;
          last_d    = gnt_m;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_d = {state_d == ST_GNT1, state_d == ST_GNT0};
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_IDLE;
      last_q    <= M1;
      burst_q   <= 4'd0;
      timeout_q <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  // Bus mux follows the registered state, so an async reset drops every
  // strobe without waiting for a clock.
  always_comb begin
    oAddr   = '0;
    oRead   = 1'b0;
    oWrite  = 1'b0;
    oBE     = 2'b00;
    oData   = '0;
    oM0_ACK = 1'b0;
    oM1_ACK = 1'b0;
    if (state_q == ST_GNT0) begin
      oAddr   = iM0_Addr;
      oWrite  = iM0_Write;
      oRead   = iM0_Read & ~iM0_Write;
      oBE     = iM0_BE;
      oData   = iM0_Data;
      oM0_ACK = iACK;
    end else if (state_q == ST_GNT1) begin
      oAddr   = iM1_Addr;
      oWrite  = iM1_Write;
      oRead   = iM1_Read & ~iM1_Write;
      oBE     = iM1_BE;
      oData   = iM1_Data;
      oM1_ACK = iACK;
    end
  end

  assign oM_RData = iRData;
  assign oGrant   = grant_q;
  assign oTimeout = timeout_q;

endmodule
